fp_convert_pipe: RTL and testbench

//  Pipelined two's-complement to sign/exponent/significand converter: value ~= (-1)^S * F * 2^E.

---
 rtl/fp_convert_pipe.sv | 169 ++++++++++++++++
 tb/tb_fp_convert_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_convert_pipe.sv
// Three-stage pipelined two's-complement to sign/exponent/significand converter
// with valid/ready flow control, saturation and a sticky saturation counter.
module fp_convert_pipe #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned EXP_W = 3,
  parameter int unsigned MAN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_count
);

  // Internal exponent width: wide enough for the pre-clamp exponent plus one.
  localparam int unsigned EW   = $clog2(IN_W) + EXP_W + 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  logic             v1_q, v2_q;
  logic             sign1_q, sign2_q;
  logic [IN_W-1:0]  mag1_q;
  logic [1:0]       rnd1_q, rnd2_q;
  logic [EW-1:0]    e2_q;
  logic [MAN_W-1:0] man2_q;
  logic             r2_q, s2_q;
  logic             ready1, ready2, ready3;

  logic [IN_W-1:0]  mag1_d;
  logic [EW-1:0]    p, e2_d;
  logic [IN_W-1:0]  shifted, rmask;
  logic [MAN_W-1:0] man2_d;
  logic             r2_d, s2_d;

  logic             inc;
  logic [MAN_W:0]   fsum;
  logic [EW-1:0]    e3;
  logic [MAN_W-1:0] f3;
  logic [EXP_W-1:0] exp_d;
  logic [MAN_W-1:0] man_d;
  logic             sat_d;

  // Ready ripples backwards so a full pipe stalls the producer in the same cycle.
  assign ready3   = ~out_valid | out_ready;
  assign ready2   = ~v2_q | ready3;
  assign ready1   = ~v1_q | ready2;
  assign in_ready = ready1;

  assign mag1_d = in_data[IN_W-1] ? IN_W'(-in_data) : in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      rnd1_q  <= '0;
    end else if (ready1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sign1_q <= in_data[IN_W-1];
        mag1_q  <= mag1_d;
        rnd1_q  <= in_rnd;
      end
    end
  end

  // Leading-one normalisation; round and sticky bits come from the discarded tail.
  always_comb begin
    p = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (mag1_q[i]) p = EW'(i);
    end
    e2_d    = '0;
    man2_d  = mag1_q[MAN_W-1:0];
    r2_d    = 1'b0;
    s2_d    = 1'b0;
    shifted = mag1_q;
    rmask   = '0;
    if (|mag1_q[IN_W-1:MAN_W]) begin
      e2_d    = p - EW'(MAN_W - 1);
      shifted = mag1_q >> e2_d;
      man2_d  = shifted[MAN_W-1:0];
      rmask   = IN_W'(1) << (e2_d - EW'(1));
      r2_d    = |(mag1_q & rmask);
      s2_d    = |(mag1_q & (rmask - IN_W'(1)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      rnd2_q  <= '0;
      e2_q    <= '0;
      man2_q  <= '0;
      r2_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else if (ready2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sign2_q <= sign1_q;
        rnd2_q  <= rnd1_q;
        e2_q    <= e2_d;
        man2_q  <= man2_d;
        r2_q    <= r2_d;
        s2_q    <= s2_d;
      end
    end
  end

  // Rounding, renormalisation on carry-out, and clamp to the largest value.
  always_comb begin
    unique case (rnd2_q)
      2'b01:   inc = r2_q;
      2'b10:   inc = r2_q & (s2_q | man2_q[0]);
      default: inc = 1'b0;
    endcase
    fsum = {1'b0, man2_q} + (MAN_W + 1)'(inc);
    e3   = e2_q;
    f3   = fsum[MAN_W-1:0];
    if (fsum[MAN_W]) begin
      f3 = {1'b1, {(MAN_W - 1){1'b0}}};
      e3 = e2_q + EW'(1);
    end
    exp_d = EXP_W'(e3);
    man_d = f3;
    sat_d = 1'b0;
    if (e3 > EW'(EMAX)) begin
      exp_d = '1;
      man_d = '1;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_man   <= '0;
      out_sat   <= 1'b0;
    end else if (ready3) begin
      out_valid <= v2_q;
      if (v2_q) begin
        out_sign <= sign2_q;
        out_exp  <= exp_d;
        out_man  <= man_d;
        out_sat  <= sat_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && !(&sat_count)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_convert_pipe.sv
// Directed bench for fp_convert_pipe: scoreboard of expected {sign,exp,man,sat}
// checked whenever the converter hands a result downstream.
module tb_fp_convert_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic [1:0]  in_rnd;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [3:0]  out_man;
  logic        out_sat;
  logic [7:0]  sat_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stall_seen = 1'b0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  fp_convert_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rnd(in_rnd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man), .out_sat(out_sat),
    .sat_count(sat_count)
  );

  function automatic logic [8:0] pk(input bit s, input int e, input int f, input bit sat);
    logic [2:0] e3;
    logic [3:0] f4;
    e3 = 3'(e);
    f4 = 4'(f);
    return {s, e3, f4, sat};
  endfunction

  // Arithmetic reference: scale down until the value fits, round on the remainder.
  function automatic logic [8:0] model(input logic [11:0] d, input logic [1:0] rnd);
    int v, m, e, f, rem, half;
    bit s, inc;
    v = int'($signed(d));
    s = (v < 0);
    m = s ? -v : v;
    e = 0;
    while ((m >> e) >= 16) e++;
    f = m >> e;
    rem = m - (f << e);
    half = (e > 0) ? (1 << (e - 1)) : 0;
    inc = 1'b0;
    if (e > 0) begin
      if (rnd == 2'b01) inc = (rem >= half);
      if (rnd == 2'b10) inc = (rem > half) || (rem == half && (f % 2) == 1);
    end
    f = f + int'(inc);
    if (f == 16) begin
      f = 8;
      e = e + 1;
    end
    if (e > 7) return pk(s, 7, 15, 1'b1);
    return pk(s, e, f, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic send(input logic [11:0] d, input logic [1:0] r, input logic [8:0] want);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_rnd   = r;
      #1;
      if (in_ready) begin
        exp_q.push_back(want);
        done = 1'b1;
        @(posedge clk);
      end else begin
        stall_seen = 1'b1;
      end
    end
    n_cmp++;
    assert (done) else begin
      n_bad++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic drain(input string tag);
    bit empty;
    empty = 1'b0;
    for (int k = 0; k < 200 && !empty; k++) begin
      @(negedge clk);
      #3;
      empty = (exp_q.size() == 0) && !out_valid;
    end
    n_cmp++;
    assert (empty) else begin
      n_bad++;
      $error("FAIL %s: observed %0d results pending expected 0", tag, exp_q.size());
    end
  endtask

  // Output monitor: compares each handed-off result and checks hold stability.
  logic [8:0] held_val;
  bit         held = 1'b0;
  always begin
    logic [8:0] cur, want;
    @(negedge clk);
    #2;
    if (rst_n) begin
      cur = {out_sign, out_exp, out_man, out_sat};
      if (held) begin
        n_cmp++;
        assert (out_valid && cur === held_val) else begin
          n_bad++;
          $error("FAIL hold: observed v=%0b %0h expected v=1 %0h", out_valid, cur, held_val);
        end
      end
      held     = out_valid && !out_ready;
      held_val = cur;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $error("FAIL extra_output: observed %0h expected no output", cur);
        end else begin
          want = exp_q.pop_front();
          assert (cur === want) else begin
            n_bad++;
            $error("FAIL result: observed %0h expected %0h", cur, want);
          end
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    logic [11:0] d;
    logic [1:0]  r;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rnd = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sat_count", 32'(sat_count), 0);
    chk("rst_outputs", 32'({out_sign, out_exp, out_man, out_sat}), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Latency of a single isolated sample.
    send(12'd422, 2'b01, pk(0, 5, 13, 0));
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_1", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_2", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_3", 32'(out_valid), 1);
    drain("drain_lat");

    send(12'd62, 2'b01, pk(0, 3, 8, 0));
    send(12'd62, 2'b00, pk(0, 2, 15, 0));
    send(12'd42, 2'b00, pk(0, 2, 10, 0));
    send(12'd42, 2'b01, pk(0, 2, 11, 0));
    send(12'd42, 2'b10, pk(0, 2, 10, 0));
    send(12'h800, 2'b00, pk(1, 7, 15, 1));
    send(12'd2047, 2'b01, pk(0, 7, 15, 1));
    send(12'hFFF, 2'b00, pk(1, 0, 1, 0));
    send(12'd0, 2'b01, pk(0, 0, 0, 0));
    send(12'd1000, 2'b11, pk(0, 6, 15, 0));
    @(negedge clk);
    in_valid = 1'b0;
    drain("drain_directed");
    chk("sat_count_2", 32'(sat_count), 2);

    // Back-pressure: downstream stalls while eight samples stream in.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          d = 12'($urandom_range(0, 1800)) - 12'd900;
          r = 2'($urandom_range(0, 3));
          send(d, r, model(d, r));
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("drain_stream");
    chk("stall_seen", 32'(stall_seen), 1);
    chk("sat_count_hold", 32'(sat_count), 2);

    // Reset with three samples in flight discards them all.
    send(12'd300, 2'b01, model(12'd300, 2'b01));
    send(12'hF00, 2'b10, model(12'hF00, 2'b10));
    send(12'd7, 2'b00, model(12'd7, 2'b00));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_outputs", 32'({out_sign, out_exp, out_man, out_sat}), 0);
    chk("mid_rst_sat_count", 32'(sat_count), 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_leftover", 32'(out_valid), 0);
    send(12'hFFF, 2'b01, pk(1, 0, 1, 0));
    @(negedge clk);
    in_valid = 1'b0;
    drain("drain_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
